// File: rtl/riscv_pkg.sv
// Shared core types and defaults.
// Holds the data-memory arbiter state type and starvation limit.
package riscv_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_RESP
  } arb_state_t;

  localparam int ARB_STARVE_MAX_DEF = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating loader wait counter.
// hit is asserted once the count reaches MAX.
module dmem_arb_starve_ctr
  import riscv_pkg::*;
#(
  parameter int MAX = ARB_STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  assign hit = (cnt_q == W'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !hit) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core MEM stage first, loader on idle or starved cycles.
// Optional stall/grant counters via DMEM_ARB_STATS_EN.
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_valid,
  input  logic            core_we,
  input  logic            core_re,
  input  logic [XLEN-1:0] core_addr,
  input  logic [XLEN-1:0] core_wdata,
  output logic [XLEN-1:0] core_rdata,
  output logic            core_stall,
  input  logic            ldr_req,
  input  logic            ldr_we,
  input  logic [XLEN-1:0] ldr_addr,
  input  logic [XLEN-1:0] ldr_wdata,
  output logic            ldr_gnt,
  output logic            ldr_rvalid,
  output logic [XLEN-1:0] ldr_rdata,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]     stat_stall_cnt,
  output logic [31:0]     stat_gnt_cnt
`endif
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       core_act;
  logic       starve_hit;

  assign core_act   = core_valid & (core_we | core_re);
  assign ldr_gnt    = ldr_req & (state_q == ARB_IDLE)
                    & (~core_act | starve_hit);
  assign core_stall = ldr_gnt & core_act;
  assign core_rdata = mem_rd;

  dmem_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (ldr_req & ~ldr_gnt),
    .clr (ldr_gnt | ~ldr_req),
    .hit (starve_hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (ldr_gnt) state_d = ARB_RESP;
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  // A stalled core store is masked so it only lands on its replay.
  always_comb begin
    mem_we   = core_we & core_valid & ~core_stall;
    mem_addr = core_addr;
    mem_wd   = core_wdata;
    if (ldr_gnt) begin
      mem_we   = ldr_we;
      mem_addr = ldr_addr & ~XLEN'(3);
      mem_wd   = ldr_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ldr_rvalid <= 1'b0;
      ldr_rdata  <= '0;
    end else begin
      ldr_rvalid <= ldr_gnt & ~ldr_we;
      if (ldr_gnt && !ldr_we) ldr_rdata <= mem_rd;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall_cnt <= '0;
      stat_gnt_cnt   <= '0;
    end else begin
      if (core_stall) stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (ldr_gnt)    stat_gnt_cnt   <= stat_gnt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word memory model.
// Counter checks are built only with DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        core_valid;
  logic        core_we;
  logic        core_re;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        ldr_req;
  logic        ldr_we;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_gnt;
  logic        ldr_rvalid;
  logic [31:0] ldr_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_stall_cnt;
  logic [31:0] stat_gnt_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n;
  logic got;

  logic [31:0] mem [0:63];

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .core_valid (core_valid),
    .core_we    (core_we),
    .core_re    (core_re),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_gnt_cnt   (stat_gnt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
  end
  assign mem_rd = mem[mem_addr[7:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic starve_run();
    step();
    core_valid = 1'b1; core_we = 1'b0; core_re = 1'b1;
    core_addr  = 32'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h10;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (ldr_gnt) break;
      step();
    end
    step();
    ldr_req = 1'b0; core_valid = 1'b0;
    step();
  endtask
`endif

  initial begin
    rst = 1'b0;
    core_valid = 1'b0; core_we = 1'b0; core_re = 1'b0;
    core_addr = '0; core_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;

    // reset state
    repeat (2) @(posedge clk);
    sample();
    chk("rst_gnt",    32'(ldr_gnt),    32'd0);
    chk("rst_rvalid", 32'(ldr_rvalid), 32'd0);
    chk("rst_rdata",  ldr_rdata,       32'd0);
    chk("rst_stall",  32'(core_stall), 32'd0);
    step();
    rst = 1'b1;

    // 1: idle core, loader write then read
    step();
    ldr_req = 1'b1; ldr_we = 1'b1;
    ldr_addr = 32'h10; ldr_wdata = 32'hDEADBEEF;
    sample();
    chk("t1_wr_gnt",   32'(ldr_gnt),    32'd1);
    chk("t1_wr_stall", 32'(core_stall), 32'd0);
    chk("t1_wr_we",    32'(mem_we),     32'd1);
    chk("t1_wr_addr",  mem_addr,        32'h10);
    chk("t1_wr_wd",    mem_wd,          32'hDEADBEEF);
    step();
    ldr_req = 1'b0;
    sample();
    chk("t1_wr_norv",  32'(ldr_rvalid), 32'd0);
    step();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h13;
    sample();
    chk("t1_rd_gnt",   32'(ldr_gnt),    32'd1);
    chk("t1_rd_addr",  mem_addr,        32'h10);
    chk("t1_rd_we",    32'(mem_we),     32'd0);
    step();
    ldr_req = 1'b0;
    sample();
    chk("t1_rvalid",   32'(ldr_rvalid), 32'd1);
    chk("t1_rdata",    ldr_rdata,       32'hDEADBEEF);
    step();
    sample();
    chk("t1_rv_pulse", 32'(ldr_rvalid), 32'd0);
    chk("t1_rd_hold",  ldr_rdata,       32'hDEADBEEF);

    // 2: core load every cycle, loader starves then steals one cycle
    step();
    core_valid = 1'b1; core_re = 1'b1; core_addr = 32'h10;
    ldr_req = 1'b1; ldr_we = 1'b1;
    ldr_addr = 32'h30; ldr_wdata = 32'h55;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t2_wait", {30'd0, ldr_gnt, core_stall}, 32'd0);
      step();
    end
    sample();
    chk("t2_gnt",    32'(ldr_gnt),    32'd1);
    chk("t2_stall",  32'(core_stall), 32'd1);
    chk("t2_maddr",  mem_addr,        32'h30);
    step();
    sample();
    chk("t2_resp",   {30'd0, ldr_gnt, core_stall}, 32'd0);
    chk("t2_replay", mem_addr,        32'h10);
    chk("t2_rdata",  core_rdata,      32'hDEADBEEF);
    chk("t2_ldrmem", mem[12],         32'h55);
    step();
    sample();
    chk("t2_nostall", {30'd0, ldr_gnt, core_stall}, 32'd0);
    step();
    ldr_req = 1'b0; core_valid = 1'b0; core_re = 1'b0;

    // 3: forced loader store vs core store to the same word
    step();
    core_valid = 1'b1; core_we = 1'b1;
    core_addr = 32'h20; core_wdata = 32'h1111;
    ldr_req = 1'b1; ldr_we = 1'b1;
    ldr_addr = 32'h20; ldr_wdata = 32'h2222;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t3_wait", {30'd0, ldr_gnt, core_stall}, 32'd0);
      step();
    end
    sample();
    chk("t3_gnt",    {30'd0, ldr_gnt, core_stall}, 32'd3);
    chk("t3_wd",     mem_wd, 32'h2222);
    step();
    ldr_req = 1'b0;
    sample();
    chk("t3_ldrwr",  mem[8],      32'h2222);
    chk("t3_replay", {31'd0, mem_we}, 32'd1);
    chk("t3_rwd",    mem_wd,      32'h1111);
    step();
    core_valid = 1'b0; core_we = 1'b0;
    sample();
    chk("t3_final",  mem[8],      32'h1111);

    // 4: withdraw at wait 5, re-request under busy core
    step();
    core_valid = 1'b1; core_re = 1'b1; core_addr = 32'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("t4_pre", 32'(ldr_gnt), 32'd0);
      step();
    end
    ldr_req = 1'b0;
    sample();
    chk("t4_drop", 32'(ldr_gnt), 32'd0);
    step();
    ldr_req = 1'b1;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (ldr_gnt) begin
        got = 1'b1;
        break;
      end
      n++;
      step();
    end
    chk("t4_got",  32'(got), 32'd1);
    chk("t4_wait", 32'(n),   32'd8);
    step();
    ldr_req = 1'b0; core_valid = 1'b0; core_re = 1'b0;
    sample();
    chk("t4_rvalid", 32'(ldr_rvalid), 32'd1);
    chk("t4_rdata",  ldr_rdata,       32'hDEADBEEF);

    // 5: reset while in RESP drops the read response
    step();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h20;
    sample();
    chk("t5_gnt", 32'(ldr_gnt), 32'd1);
    step();
    ldr_req = 1'b0;
    rst = 1'b0;
    sample();
    chk("t5_rv0",    32'(ldr_rvalid), 32'd0);
    chk("t5_rdata",  ldr_rdata,       32'd0);
    chk("t5_outs",   {29'd0, ldr_gnt, core_stall, mem_we}, 32'd0);
    step();
    sample();
    chk("t5_rv1",    32'(ldr_rvalid), 32'd0);
    step();
    rst = 1'b1;
    sample();
    chk("t5_rv2",    32'(ldr_rvalid), 32'd0);
    step();
    sample();
    chk("t5_rv3",    32'(ldr_rvalid), 32'd0);

`ifdef DMEM_ARB_STATS_EN
    // 6: counters after reset, then two starvation episodes
    chk("t6_rst_stall", stat_stall_cnt, 32'd0);
    chk("t6_rst_gnt",   stat_gnt_cnt,   32'd0);
    starve_run();
    starve_run();
    sample();
    chk("t6_stall", stat_stall_cnt, 32'd2);
    chk("t6_gnt",   stat_gnt_cnt,   32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
